// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified memory-port arbiter.
package mem_arb_pkg;

    // Largest wait budget the 8-bit wait counter can express.
    localparam int unsigned MAX_WAIT_LIMIT = 255;

    // Width of the address/data fields held in the captured request.
    localparam int unsigned REQ_ADDR_W = 32;
    localparam int unsigned REQ_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } arb_owner_e;

    // Request as presented to the memory port while an access is in flight.
    typedef struct packed {
        logic                  we;
        logic                  byte_acc;
        logic                  half;
        logic                  sext;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } arb_req_t;

    // Force a wait budget into the legal 1..MAX_WAIT_LIMIT range.
    function automatic logic [7:0] clamp_wait(input int unsigned w);
        if (w < 1) begin
            return 8'd1;
        end else if (w > MAX_WAIT_LIMIT) begin
            return 8'(MAX_WAIT_LIMIT);
        end else begin
            return 8'(w);
        end
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// 8-bit saturating wait counter with clear, load and enable, flagging
// the last cycle an access may wait before it is aborted.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    output logic       expired_o
);

    localparam logic [7:0] EXPIRE_AT = clamp_wait(MAX_WAIT) - 8'd1;

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear beats load beats increment; never wraps past 0xFF.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access.
// Optional macro MEM_ARB_RR_EN: round-robin on contention instead of
// fixed data-over-fetch priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    // fetch side
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    // data side
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic              d_half,
    input  logic              d_sext,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_byte,
    output logic              mem_half,
    output logic              mem_sext,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // core stall
    output logic              busy
);

    arb_state_e  state_q;
    arb_owner_e  owner_q;
    arb_owner_e  owner_d;
    arb_req_t    req_q;
    arb_req_t    req_d;

    logic              mem_req_q;
    logic              busy_q;
    logic              i_ready_q;
    logic              i_err_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic              d_ready_q;
    logic              d_err_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              prefer_d;
    logic              expired;
    logic              acc_done;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;

    // Remember whether data won the most recent grant so contention alternates.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else if ((state_q == IDLE) && (owner_d != OWN_NONE)) begin
            last_d_q <= (owner_d == OWN_D);
        end
    end

    assign prefer_d = ~last_d_q;
`else
    assign prefer_d = 1'b1;
`endif

    // Pick the next owner and build the request it would present.
    always_comb begin
        owner_d = OWN_NONE;
        req_d   = '0;
        if (d_req && (!i_req || prefer_d)) begin
            owner_d = OWN_D;
        end else if (i_req) begin
            owner_d = OWN_I;
        end
        if (owner_d == OWN_D) begin
            req_d.we       = d_we;
            req_d.byte_acc = d_byte;
            req_d.half     = d_half;
            req_d.sext     = d_sext;
            req_d.addr     = REQ_ADDR_W'(d_addr);
            req_d.wdata    = REQ_DATA_W'(d_wdata);
        end else if (owner_d == OWN_I) begin
            req_d.addr     = REQ_ADDR_W'(i_addr);
        end
    end

    mem_arb_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .clr_i      (state_q == IDLE),
        .load_i     (1'b0),
        .load_val_i (8'd0),
        .en_i       ((state_q == ACCESS) && !mem_ready),
        .expired_o  (expired)
    );

    // A real completion takes precedence over a timeout in the same cycle.
    always_comb begin
        acc_done  = (state_q == ACCESS) && (mem_ready || expired);
        rsp_err   = !mem_ready;
        rsp_rdata = mem_ready ? mem_rdata : '0;
    end

    // Main FSM: grant in IDLE, hold the port in ACCESS, pulse ready in RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            req_q     <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            i_ready_q <= 1'b0;
            i_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_ready_q <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (owner_d != OWN_NONE) begin
                        owner_q   <= owner_d;
                        req_q     <= req_d;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (acc_done) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (owner_q == OWN_I) begin
                            i_ready_q <= 1'b1;
                            i_rdata_q <= rsp_rdata;
                            i_err_q   <= rsp_err;
                        end else begin
                            d_ready_q <= 1'b1;
                            d_rdata_q <= rsp_rdata;
                            d_err_q   <= rsp_err;
                        end
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    owner_q <= OWN_NONE;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_ready   = i_ready_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = req_q.we;
    assign mem_byte  = req_q.byte_acc;
    assign mem_half  = req_q.half;
    assign mem_sext  = req_q.sext;
    assign mem_addr  = ADDR_W'(req_q.addr);
    assign mem_wdata = DATA_W'(req_q.wdata);
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; honours MEM_ARB_RR_EN when defined.
module tb_mem_port_arbiter;

    localparam int NEVER = 1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, i_ready, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_byte, d_half, d_sext, d_ready, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_byte, mem_half, mem_sext, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we, bt, hf, sx;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    grant_t grant_q[$];
    rsp_t   i_exp_q[$];
    rsp_t   d_exp_q[$];
    grant_t g_cur;
    logic   mreq_prev = 1'b0;
    int     mreq_len = 0;
    int     last_mreq_len = 0;
    int     d_pulses = 0;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_byte    (d_byte),
        .d_half    (d_half),
        .d_sext    (d_sext),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_half  (mem_half),
        .mem_sext  (mem_sext),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [31:0] a);
        return ((a - 32'h100) * 32'h9E3779B1) ^ 32'h8C010004;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Memory model: answers mem_req after mem_lat waiting cycles.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            step();
            if (mem_req) begin
                if (cnt == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = model(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: responses against per-requester queues, port contents against grant queue.
    always @(negedge clock) begin
        rsp_t e;
        if (!reset) begin
            if (i_ready && d_ready) check("both_ready", 1, 0);
            if (i_ready) begin
                if (i_exp_q.size() == 0) check("i_unexpected", 1, 0);
                else begin
                    e = i_exp_q.pop_front();
                    check("i_rdata", i_rdata, e.rdata);
                    check("i_err", i_err, e.err);
                end
            end
            if (d_ready) begin
                d_pulses++;
                if (d_exp_q.size() == 0) check("d_unexpected", 1, 0);
                else begin
                    e = d_exp_q.pop_front();
                    check("d_rdata", d_rdata, e.rdata);
                    check("d_err", d_err, e.err);
                end
            end
            if (mem_req) begin
                if (!mreq_prev) begin
                    mreq_len = 0;
                    if (grant_q.size() == 0) check("grant_unexpected", 1, 0);
                    else g_cur = grant_q.pop_front();
                end
                mreq_len++;
                check("mem_addr", mem_addr, g_cur.addr);
                check("mem_attr", {mem_we, mem_byte, mem_half, mem_sext},
                      {g_cur.we, g_cur.bt, g_cur.hf, g_cur.sx});
                check("mem_wdata", mem_wdata, g_cur.wdata);
                check("busy_in_access", busy, 1);
            end
        end
        if (!mem_req && mreq_prev) last_mreq_len = mreq_len;
        mreq_prev = mem_req;
    end

    task automatic push_grant(input logic [31:0] a, input logic we, input logic bt,
                              input logic hf, input logic sx, input logic [31:0] wd);
        grant_t g;
        g.addr = a; g.we = we; g.bt = bt; g.hf = hf; g.sx = sx; g.wdata = wd;
        grant_q.push_back(g);
    endtask

    function automatic rsp_t exp_rsp(input logic [31:0] a);
        rsp_t r;
        r.err   = (mem_lat >= 15);
        r.rdata = r.err ? 32'h0 : model(a);
        return r;
    endfunction

    task automatic drive_i(input logic [31:0] a, input bit pg, output int lat);
        if (pg) push_grant(a, 0, 0, 0, 0, 0);
        i_exp_q.push_back(exp_rsp(a));
        i_req = 1'b1;
        i_addr = a;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!i_ready && lat < 300);
        if (!i_ready) check("i_no_ready", 0, 1);
        i_req = 1'b0;
    endtask

    task automatic drive_d(input logic [31:0] a, input logic we, input logic bt,
                           input logic hf, input logic sx, input logic [31:0] wd,
                           input bit pg, output int lat);
        if (pg) push_grant(a, we, bt, hf, sx, wd);
        d_exp_q.push_back(exp_rsp(a));
        d_req = 1'b1; d_addr = a; d_we = we; d_byte = bt; d_half = hf;
        d_sext = sx; d_wdata = wd;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!d_ready && lat < 300);
        if (!d_ready) check("d_no_ready", 0, 1);
        d_req = 1'b0;
    endtask

    task automatic contention(input string tag, input bit d_first);
        int li, ld;
        mem_lat = 2;
        if (d_first) begin
            push_grant(32'h4000, 0, 0, 0, 0, 0);
            push_grant(32'h0200, 0, 0, 0, 0, 0);
        end else begin
            push_grant(32'h0200, 0, 0, 0, 0, 0);
            push_grant(32'h4000, 0, 0, 0, 0, 0);
        end
        fork
            drive_d(32'h4000, 0, 0, 0, 0, 0, 0, ld);
            drive_i(32'h0200, 0, li);
        join
        check({tag, "_d_lat"}, ld, d_first ? 4 : 9);
        check({tag, "_i_lat"}, li, d_first ? 9 : 4);
        step();
    endtask

    initial begin
        int lat, n, p0;
        reset = 1'b1;
        i_req = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_byte = 0; d_half = 0; d_sext = 0; d_addr = 0; d_wdata = 0;
        repeat (3) step();
        check("rst_ctrl", {i_ready, i_err, d_ready, d_err, mem_req, mem_we, mem_byte,
                           mem_half, mem_sext, busy}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        check("rst_mem", {mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        step();

        // Single fetch, memory answers in the first ACCESS cycle.
        mem_lat = 0;
        drive_i(32'h100, 1, lat);
        check("fetch_lat", lat, 2);
        step();

        // Simultaneous requests: data first in both builds.
        contention("cont1", 1);

        // Solo data load with sign-extended half word.
        mem_lat = 1;
        drive_d(32'h3002, 0, 0, 1, 1, 0, 1, lat);
        check("load_lat", lat, 3);
        step();

`ifdef MEM_ARB_RR_EN
        contention("cont2", 0);
`else
        contention("cont2", 1);
`endif

        // Byte store held stable for a 3-cycle memory latency.
        mem_lat = 3;
        p0 = d_pulses;
        drive_d(32'h2003, 1, 1, 0, 0, 32'hAB, 1, lat);
        check("store_lat", lat, 5);
        repeat (3) step();
        check("store_pulses", d_pulses - p0, 1);

        // Fetch that never completes.
        mem_lat = NEVER;
        drive_i(32'h300, 1, lat);
        check("to_lat", lat, 16);
        step();
        check("to_mreq_len", last_mreq_len, 15);
        check("to_idle", {busy, mem_req}, 0);
        step();

        // Reset in the third ACCESS cycle of a load abandons it.
        mem_lat = 10;
        push_grant(32'h600, 0, 0, 0, 0, 0);
        d_req = 1; d_addr = 32'h600; d_we = 0; d_byte = 0; d_half = 0; d_sext = 0; d_wdata = 0;
        repeat (3) step();
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        d_req = 1'b0;
        step();
        check("rst_abort", {mem_req, busy, d_ready}, 0);
        check("rst_abort_rdata", d_rdata, 0);
        reset = 1'b0;
        repeat (3) step();
        check("rst_no_ready", d_pulses - p0, 1);
        mem_lat = 2;
        drive_d(32'h604, 0, 0, 0, 0, 0, 1, lat);
        check("post_rst_lat", lat, 4);
        step();

        // Data request held through its ready cycle: no regrant in RESP.
        mem_lat = 0;
        push_grant(32'h500, 0, 0, 0, 0, 0);
        push_grant(32'h500, 0, 0, 0, 0, 0);
        d_exp_q.push_back(exp_rsp(32'h500));
        d_exp_q.push_back(exp_rsp(32'h500));
        d_req = 1; d_addr = 32'h500; d_we = 0; d_byte = 0; d_half = 0; d_sext = 0; d_wdata = 0;
        n = 0;
        do begin step(); n++; end while (!d_ready && n < 50);
        check("hold_first", d_ready, 1);
        check("hold_resp_mreq", mem_req, 0);
        step();
        check("hold_idle", {mem_req, busy}, 0);
        step();
        check("hold_regrant", mem_req, 1);
        n = 0;
        do begin step(); n++; end while (!d_ready && n < 50);
        check("hold_second", d_ready, 1);
        d_req = 1'b0;
        repeat (2) step();

        // Mixed sequential traffic with varied latency and attributes.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a, wd;
            logic [3:0] at;
            mem_lat = $urandom_range(0, 5);
            a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            wd = $urandom;
            at = 4'($urandom_range(0, 15));
            if (k % 2 == 0) begin
                drive_i(a, 1, lat);
            end else begin
                drive_d(a, at[0], at[1], at[2], at[3], wd, 1, lat);
            end
            check("mix_lat", lat, mem_lat + 2);
            step();
        end

        repeat (3) step();
        check("sb_empty", {32'(grant_q.size()), 16'(i_exp_q.size()), 16'(d_exp_q.size())}, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical memory port between the instruction-fetch requester (IFU) and the data-access requester (MEM stage).
- Lets the processor run on a unified, variable-latency memory instead of separate IMEM/DMEM.
- Serialises accesses with a req/ready handshake on each side and a timeout with error response.
- Sits between the processor core and the memory model; exposes a `busy` flag for core stall logic.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_WAIT, 15, ACCESS cycles without mem_ready before the access is aborted with error; legal range 1..255

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  one-cycle completion pulse for fetch
- i_rdata  out  DATA_W  fetched word, valid while i_ready=1
- i_err  out  1  fetch timed out, valid while i_ready=1
- d_req  in  1  data request; held with all d_* inputs stable until d_ready
- d_we  in  1  1=store, 0=load
- d_byte  in  1  byte access
- d_half  in  1  half-word access
- d_sext  in  1  sign-extend load result
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load data, valid while d_ready=1
- d_err  out  1  data access timed out, valid while d_ready=1
- mem_req  out  1  access request to memory
- mem_we, mem_byte, mem_half, mem_sext  out  1 each  registered copies of the owner's attributes; all 0 for fetch
- mem_addr  out  ADDR_W  registered owner address
- mem_wdata  out  DATA_W  registered store data; 0 for fetch
- mem_rdata  in  DATA_W  read data, sampled when mem_ready=1
- mem_ready  in  1  memory completion; may assert in the first cycle mem_req=1
- busy  out  1  1 in ACCESS and RESP states

Behaviour:
- Reset:
  - synchronous; state=IDLE, owner=NONE, wait counter=0.
  - All outputs 0, including rdata/err registers.
  - Reset during ACCESS abandons the transaction: mem_req=0 on the next cycle, no ready pulse to either requester.
- FSM IDLE:
  - no req: stay in IDLE.
  - otherwise grant per priority and capture the owner's address/attributes/wdata into registers.
  - counter:=0; go to ACCESS.
- Priority (default): d_req beats i_req when both are high in the same IDLE cycle.
- FSM ACCESS:
  - mem_req=1; mem_* outputs driven from the captured registers.
  - mem_ready=1: capture mem_rdata, err:=0, go to RESP.
  - mem_ready=0 and counter==MAX_WAIT-1: rdata:=0, err:=1, go to RESP.
  - otherwise counter+1 and stay in ACCESS.
- FSM RESP:
  - mem_req=0; owner's ready=1 for exactly this cycle, with its rdata/err; the non-owner's ready stays 0.
  - Requests are ignored this cycle, so a still-high req cannot cause a double grant.
  - Next state is IDLE.
- Latency:
  - req seen in IDLE at cycle T; mem_req high from T+1.
  - mem_ready at cycle T+1+k (k ≥ 0) gives ready at T+2+k.
  - Minimum 3 cycles per access.
- mem_ready while mem_req=0 is ignored.
- Counter is 8 bits and saturates; it never wraps within one access.
- A requester dropping req before its ready pulse is illegal. The arbiter still completes the access and pulses ready.
- A load that times out returns rdata=0; a store that times out has undefined memory effect.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration using a 1-bit last-grant register. On simultaneous requests, grant the requester not granted last. The register resets to "instruction", so the first contention goes to data. It updates on every grant.
- Undefined: fixed data-over-instruction priority; no last-grant register.
- Single-requester behaviour is identical in both builds.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - owner enum {OWN_NONE, OWN_I, OWN_D}
  - packed request struct {we, byte, half, sext, addr, wdata}
  - MAX_WAIT_LIMIT=255
- Sub-module mem_arb_timer: loadable 8-bit saturating wait counter with clear, enable and an expiry compare against MAX_WAIT.

Test Plan:
- i_req=1, i_addr=0x100, mem_ready=1 in the first ACCESS cycle, mem_rdata=0x8C010004:
  - i_ready pulses at cycle T+2 with i_rdata=0x8C010004, i_err=0
  - mem_we=mem_byte=mem_half=mem_sext=0 during the access
- d_req and i_req rise together, memory latency 2:
  - fixed build: data served first (mem_addr=d_addr), fetch granted in the IDLE cycle after d_ready
  - MEM_ARB_RR_EN build: data first, then on the next contention fetch first
- d_req store, d_byte=1, d_addr=0x2003, d_wdata=0xAB:
  - mem_we=1, mem_byte=1, mem_addr=0x2003, mem_wdata=0xAB held stable until mem_ready
  - exactly one d_ready pulse
- i_req with mem_ready never asserted, MAX_WAIT=15:
  - mem_req high for exactly 15 cycles
  - i_ready pulse with i_err=1, i_rdata=0
  - arbiter returns to IDLE
- Reset asserted in the third ACCESS cycle of a data load:
  - next cycle mem_req=0, busy=0, no d_ready pulse
  - a fresh d_req after reset completes normally
- Requester holds d_req high through its d_ready cycle with no other request:
  - no regrant in RESP
  - a new access starts from IDLE the following cycle (one access per request edge, handled by the bench)
